// File: rtl/seg7_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the scanned 7-segment display bus and the decoded results.
//   seg         : segment bus, active-low, seg[7]=DP, seg[6:0]=abcdefg
//   an          : digit anode strobes, active-low, an[k]=0 selects digit k
//   hex_out     : captured hex value, digit k in hex_out[4k+3:4k]
//   dp_out      : captured decimal point per digit, 1 = lit
//   digit_valid : 1 = digit k holds a legal captured hex pattern
//   err         : 1 = last capture on digit k was non-hex and non-blank
//   frame_done  : one-cycle pulse once all four digits have been captured
// master drives the display pins (stimulus side), slave is the decoder.
// ---------------------------------------------------------------------------
interface seg7_scan_decoder_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic [3:0]  err;
    logic        frame_done;

    modport master (
        output seg, an,
        input  hex_out, dp_out, digit_valid, err, frame_done
    );

    modport slave (
        input  seg, an,
        output hex_out, dp_out, digit_valid, err, frame_done
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Snoops a multiplexed 4-digit 7-segment display and recovers the shown hex
// digits. Pins are synchronized, a digit is captured once its sample has
// been stable for STABLE_CYCLES consecutive cycles, and a pulse marks each
// completed frame (all four digits captured).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_decoder_if.slave (pins in, decoded results out)
// All outputs are registered; no combinational input-to-output path.
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_decoder_if.slave   bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

    logic [7:0]  seg_m, seg_s;
    logic [3:0]  an_m, an_s;
    logic [11:0] prev_sample;
    logic [7:0]  cnt;
    logic [3:0]  seen;

    logic [15:0] hex_q;
    logic [3:0]  dp_q;
    logic [3:0]  valid_q;
    logic [3:0]  err_q;
    logic        fd_q;

    logic [11:0] sample;
    logic        selectable;
    logic        same;
    logic        capture;
    logic [1:0]  sel_idx;
    logic [3:0]  dec_val;
    logic        dec_legal;
    logic        blank;
    logic [3:0]  seen_next;

    // Two-flop synchronizers; reset to all ones = idle, no digit selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= 8'hFF;
            seg_s <= 8'hFF;
            an_m  <= 4'hF;
            an_s  <= 4'hF;
        end else begin
            seg_m <= bus.seg;
            seg_s <= seg_m;
            an_m  <= bus.an;
            an_s  <= an_m;
        end
    end

    assign sample     = {an_s, seg_s};
    assign selectable = $onehot(~an_s);
    assign same       = (sample == prev_sample);
    // Fires only on the advance ARM -> MAX, so a saturated run never recaptures.
    assign capture    = selectable && same && (cnt == CNT_ARM);
    assign blank      = (seg_s[6:0] == 7'b1111111);

    always_comb begin
        sel_idx = 2'd0;
        case (an_s)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        case (seg_s[6:0])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign seen_next = seen | (4'b0001 << sel_idx);

    // Stability counter; any sample change (anode or segment) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample <= 12'hFFF;
            cnt         <= 8'd0;
        end else begin
            prev_sample <= sample;
            if (!selectable || !same) begin
                cnt <= 8'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= 16'h0000;
            dp_q    <= 4'h0;
            valid_q <= 4'h0;
            err_q   <= 4'h0;
            fd_q    <= 1'b0;
            seen    <= 4'h0;
        end else begin
            fd_q <= 1'b0;
            if (capture) begin
                dp_q[sel_idx] <= ~seg_s[7];
                if (dec_legal) begin
                    hex_q[{sel_idx, 2'b00} +: 4] <= dec_val;
                    valid_q[sel_idx]             <= 1'b1;
                    err_q[sel_idx]               <= 1'b0;
                end else begin
                    valid_q[sel_idx] <= 1'b0;
                    err_q[sel_idx]   <= !blank;
                end
                if (seen_next == 4'hF) begin
                    fd_q <= 1'b1;
                    seen <= 4'h0;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.err         = err_q;
    assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed stimulus for seg7_scan_decoder (STABLE_CYCLES = 4). Inputs change
// and outputs are sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_count = 0;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_count++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg);
        bus.an  = an;
        bus.seg = seg;
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] hex, input logic [3:0] dp,
                           input logic [3:0] vld, input logic [3:0] er);
        chk({tag, ".hex"},   bus.hex_out, hex);
        chk({tag, ".dp"},    {12'h0, bus.dp_out}, {12'h0, dp});
        chk({tag, ".valid"}, {12'h0, bus.digit_valid}, {12'h0, vld});
        chk({tag, ".err"},   {12'h0, bus.err}, {12'h0, er});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'hF, 8'hFF);
        repeat (3) @(negedge clk);
        chk_all("reset", 16'h0000, 4'h0, 4'h0, 4'h0);
        chk("reset.fd", {15'h0, bus.frame_done}, 16'h0);
        rst_n = 1'b1;
        wait_edges(2);

        // Static digit 2 on digit 0, exact latency: capture on 6th edge
        drive(4'b1110, 8'b1_0010010);
        wait_edges(5);
        chk_all("static.early", 16'h0000, 4'h0, 4'h0, 4'h0);
        wait_edges(1);
        chk_all("static.cap", 16'h0002, 4'h0, 4'h1, 4'h0);
        wait_edges(4);
        chk_all("static.hold", 16'h0002, 4'h0, 4'h1, 4'h0);

        // Full scan 1, A, b(DP), F
        drive(4'b1110, 8'b1_1001111); wait_edges(8);
        drive(4'b1101, 8'b1_0001000); wait_edges(8);
        drive(4'b1011, 8'b0_1100000); wait_edges(8);
        chk("scan.nofd_yet", 16'(fd_count), 16'd0);
        drive(4'b0111, 8'b1_0111000);
        wait_edges(5);
        chk("scan.fd_before", {15'h0, bus.frame_done}, 16'h0);
        wait_edges(1);
        chk("scan.fd_pulse", {15'h0, bus.frame_done}, 16'h1);
        wait_edges(1);
        chk("scan.fd_after", {15'h0, bus.frame_done}, 16'h0);
        wait_edges(1);
        chk_all("scan", 16'hFBA1, 4'b0100, 4'hF, 4'h0);
        chk("scan.fd_count", 16'(fd_count), 16'd1);

        // Glitch: pattern 3 on digit 0 for 3 cycles only
        drive(4'b1110, 8'b1_0000110); wait_edges(3);
        drive(4'hF, 8'hFF);           wait_edges(10);
        chk_all("glitch", 16'hFBA1, 4'b0100, 4'hF, 4'h0);
        // Same pattern for 4 cycles is just enough
        drive(4'b1110, 8'b1_0000110); wait_edges(4);
        drive(4'hF, 8'hFF);           wait_edges(10);
        chk_all("glitch.min", 16'hFBA3, 4'b0100, 4'hF, 4'h0);

        // Illegal then blank on digit 1
        drive(4'b1101, 8'b1_1111110); wait_edges(8);
        chk_all("illegal", 16'hFBA3, 4'b0100, 4'b1101, 4'b0010);
        drive(4'b1101, 8'b1_1111111); wait_edges(8);
        chk_all("blank", 16'hFBA3, 4'b0100, 4'b1101, 4'b0000);

        // Ghosting: two anodes low, then none
        drive(4'b1100, 8'b1_0000000); wait_edges(20);
        chk_all("ghost", 16'hFBA3, 4'b0100, 4'b1101, 4'b0000);
        drive(4'b1111, 8'b1_0000000); wait_edges(10);
        chk_all("none", 16'hFBA3, 4'b0100, 4'b1101, 4'b0000);

        // Anode change with same seg bits restarts the count
        drive(4'b1011, 8'b1_0000000); wait_edges(3);
        drive(4'b0111, 8'b1_0000000); wait_edges(3);
        drive(4'hF, 8'hFF);           wait_edges(10);
        chk_all("an_change", 16'hFBA3, 4'b0100, 4'b1101, 4'b0000);
        drive(4'b0111, 8'b1_0000000); wait_edges(8);
        chk_all("digit3_8", 16'h8BA3, 4'b0100, 4'b1101, 4'b0000);
        chk("fd_total", 16'(fd_count), 16'd1);

        // Reset mid-run at counter = 2 on digit 0
        drive(4'b1110, 8'b1_0010010);
        wait_edges(5);
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 16'h0000, 4'h0, 4'h0, 4'h0);
        chk("midrst.fd", {15'h0, bus.frame_done}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(5);
        chk_all("midrst.early", 16'h0000, 4'h0, 4'h0, 4'h0);
        wait_edges(1);
        chk_all("midrst.cap", 16'h0002, 4'h0, 4'h1, 4'h0);
        wait_edges(4);
        chk("end.fd_count", 16'(fd_count), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
